// File: rtl/zeroheti_irq_nest_ctrl.sv
// Interrupt nesting controller between the IC and the core: level stack, request/ack sequencing.
// Optional statistics counters are built when ZEROHETI_NEST_STATS_EN is defined.
module zeroheti_irq_nest_ctrl #(
    parameter int unsigned NrIrqs     = 64,
    parameter int unsigned NrPrios    = 8,
    parameter int unsigned StackDepth = 4,
    localparam int unsigned IrqWidth  = $clog2(NrIrqs),
    localparam int unsigned PrioWidth = $clog2(NrPrios),
    localparam int unsigned DepthW    = $clog2(StackDepth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 irq_valid_i,
    input  logic [IrqWidth-1:0]  irq_id_i,
    input  logic [PrioWidth-1:0] irq_level_i,
    output logic                 irq_ack_o,
    output logic [IrqWidth-1:0]  irq_ack_id_o,
    output logic                 irq_req_o,
    output logic [IrqWidth-1:0]  irq_id_o,
    output logic [PrioWidth-1:0] irq_level_o,
    input  logic                 irq_take_i,
    input  logic                 mret_i,
    output logic [PrioWidth-1:0] threshold_o,
    output logic [DepthW-1:0]    depth_o,
    output logic                 nest_full_o,
    output logic                 underflow_o,
    output logic [15:0]          stat_preempt_o,
    output logic [DepthW-1:0]    stat_maxdep_o
);

    typedef enum logic [1:0] {IDLE, PEND, ACK, GUARD} state_e;

    state_e               state_q, state_d;
    logic [IrqWidth-1:0]  cap_id_q, cap_id_d;
    logic [PrioWidth-1:0] cap_lvl_q, cap_lvl_d;
    logic                 req_q, req_d;
    logic                 ack_q, ack_d;
    logic [IrqWidth-1:0]  ack_id_q, ack_id_d;
    logic [PrioWidth-1:0] stack_q [StackDepth];
    logic [PrioWidth-1:0] stack_d [StackDepth];
    logic [DepthW-1:0]    depth_q, depth_d;
    logic                 underflow_q, underflow_d;

    logic [PrioWidth-1:0] top_lvl;
    logic                 full;
    logic                 pop;
    logic                 take_ok;

    // Top-of-stack mux; an empty stack reads as thread level 0.
    always_comb begin
        top_lvl = '0;
        for (int i = 0; i < StackDepth; i++) begin
            if (DepthW'(i + 1) == depth_q) begin
                top_lvl = stack_q[i];
            end
        end
    end

    assign full    = (depth_q == DepthW'(StackDepth));
    assign pop     = mret_i && (depth_q != '0);
    assign take_ok = (state_q == PEND) && irq_take_i && (!full || mret_i);

    always_comb begin
        state_d     = state_q;
        cap_id_d    = cap_id_q;
        cap_lvl_d   = cap_lvl_q;
        stack_d     = stack_q;
        depth_d     = depth_q;
        underflow_d = underflow_q | (mret_i && (depth_q == '0));

        unique case (state_q)
            IDLE: begin
                if (irq_valid_i && (irq_level_i > top_lvl) && !full) begin
                    state_d   = PEND;
                    cap_id_d  = irq_id_i;
                    cap_lvl_d = irq_level_i;
                end
            end
            PEND: begin
                if (take_ok) begin
                    state_d = ACK;
                end else if (!irq_valid_i) begin
                    state_d = IDLE;
                end else if ((irq_level_i > cap_lvl_q) || (irq_id_i != cap_id_q)) begin
                    cap_id_d  = irq_id_i;
                    cap_lvl_d = irq_level_i;
                end
            end
            ACK:     state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Simultaneous take and mret overwrites the top entry instead of moving depth.
        for (int i = 0; i < StackDepth; i++) begin
            if (take_ok && (pop ? (DepthW'(i + 1) == depth_q) : (DepthW'(i) == depth_q))) begin
                stack_d[i] = cap_lvl_q;
            end
        end
        if (take_ok && !pop) begin
            depth_d = depth_q + DepthW'(1);
        end else if (!take_ok && pop) begin
            depth_d = depth_q - DepthW'(1);
        end

        req_d    = (state_d == PEND);
        ack_d    = (state_d == ACK);
        ack_id_d = (state_d == ACK) ? cap_id_q : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cap_id_q    <= '0;
            cap_lvl_q   <= '0;
            req_q       <= 1'b0;
            ack_q       <= 1'b0;
            ack_id_q    <= '0;
            stack_q     <= '{default: '0};
            depth_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_id_q    <= cap_id_d;
            cap_lvl_q   <= cap_lvl_d;
            req_q       <= req_d;
            ack_q       <= ack_d;
            ack_id_q    <= ack_id_d;
            stack_q     <= stack_d;
            depth_q     <= depth_d;
            underflow_q <= underflow_d;
        end
    end

    assign irq_req_o    = req_q;
    assign irq_id_o     = cap_id_q;
    assign irq_level_o  = cap_lvl_q;
    assign irq_ack_o    = ack_q;
    assign irq_ack_id_o = ack_id_q;
    assign threshold_o  = top_lvl;
    assign depth_o      = depth_q;
    assign nest_full_o  = full;
    assign underflow_o  = underflow_q;

`ifdef ZEROHETI_NEST_STATS_EN
    logic [15:0]       preempt_q, preempt_d;
    logic [DepthW-1:0] maxdep_q, maxdep_d;

    // A push counts as a preemption when some handler is already active.
    always_comb begin
        preempt_d = preempt_q;
        maxdep_d  = maxdep_q;
        if (take_ok && (depth_q != '0) && (preempt_q != 16'hFFFF)) begin
            preempt_d = preempt_q + 16'd1;
        end
        if (depth_d > maxdep_q) begin
            maxdep_d = depth_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            preempt_q <= '0;
            maxdep_q  <= '0;
        end else begin
            preempt_q <= preempt_d;
            maxdep_q  <= maxdep_d;
        end
    end

    assign stat_preempt_o = preempt_q;
    assign stat_maxdep_o  = maxdep_q;
`else
    assign stat_preempt_o = '0;
    assign stat_maxdep_o  = '0;
`endif

endmodule

// File: tb/tb_zeroheti_irq_nest_ctrl.sv
// Self-checking bench for zeroheti_irq_nest_ctrl: directed scenarios plus random traffic vs. a queue-based model.
module tb_zeroheti_irq_nest_ctrl;

    logic       clk;
    logic       rst;
    logic       irq_valid;
    logic [5:0] irq_id;
    logic [2:0] irq_level;
    logic       take;
    logic       mret;
    logic       ack;
    logic [5:0] ack_id;
    logic       req;
    logic [5:0] id_o;
    logic [2:0] lvl_o;
    logic [2:0] thr;
    logic [2:0] depth;
    logic       full;
    logic       uf;
    logic [15:0] st_pre;
    logic [2:0] st_max;

    int total = 0;
    int bad   = 0;

    // Reference model: pending request, ack pulse, capture blackout, level stack as a queue.
    bit m_pend;
    int m_pid, m_plvl;
    bit m_ack;
    int m_ackid;
    int m_block;
    int m_stk[$];
    bit m_uf;
    int m_npre, m_maxd;

    zeroheti_irq_nest_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .irq_valid_i    (irq_valid),
        .irq_id_i       (irq_id),
        .irq_level_i    (irq_level),
        .irq_ack_o      (ack),
        .irq_ack_id_o   (ack_id),
        .irq_req_o      (req),
        .irq_id_o       (id_o),
        .irq_level_o    (lvl_o),
        .irq_take_i     (take),
        .mret_i         (mret),
        .threshold_o    (thr),
        .depth_o        (depth),
        .nest_full_o    (full),
        .underflow_o    (uf),
        .stat_preempt_o (st_pre),
        .stat_maxdep_o  (st_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        int  size;
        int  cur_thr;
        bit  is_full;
        bit  do_pop;
        bit  took;
        bit  nack;
        if (rst) begin
            m_pend = 0; m_pid = 0; m_plvl = 0; m_ack = 0; m_ackid = 0;
            m_block = 0; m_stk.delete(); m_uf = 0; m_npre = 0; m_maxd = 0;
            return;
        end
        size    = m_stk.size();
        cur_thr = (size > 0) ? m_stk[size-1] : 0;
        is_full = (size == 4);
        do_pop  = mret && (size > 0);
        took    = 0;
        nack    = 0;
        if (mret && size == 0) m_uf = 1;
        if (m_pend) begin
            if (take && (!is_full || mret)) begin
                took = 1;
                if (size >= 1 && m_npre < 65535) m_npre++;
                if (do_pop) void'(m_stk.pop_back());
                m_stk.push_back(m_plvl);
                m_pend  = 0;
                nack    = 1;
                m_ackid = m_pid;
                m_block = 2;
            end else if (!irq_valid) begin
                m_pend = 0;
            end else if (int'(irq_level) > m_plvl || int'(irq_id) != m_pid) begin
                m_pid  = irq_id;
                m_plvl = irq_level;
            end
        end else if (m_block > 0) begin
            m_block--;
        end else if (irq_valid && int'(irq_level) > cur_thr && !is_full) begin
            m_pend = 1;
            m_pid  = irq_id;
            m_plvl = irq_level;
        end
        if (do_pop && !took) void'(m_stk.pop_back());
        m_ack = nack;
        if (m_stk.size() > m_maxd) m_maxd = m_stk.size();
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1; irq_valid = 0; take = 0; mret = 0;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic push_level(input logic [5:0] id, input logic [2:0] lvl);
        irq_valid = 1; irq_id = id; irq_level = lvl;
        tick();
        take = 1;
        tick();
        take = 0; irq_valid = 0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        irq_id = 0; irq_level = 0;
        apply_reset();
        total++; if (req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%0d want=0", req); end
        total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack got=%0d want=0", ack); end
        total++; if (depth !== 3'd0) begin bad++; $display("[TB] FAIL reset_depth got=%0d want=0", depth); end
        total++; if (thr !== 3'd0) begin bad++; $display("[TB] FAIL reset_thr got=%0d want=0", thr); end
        total++; if ({full, uf, id_o, lvl_o, ack_id} !== '0) begin bad++; $display("[TB] FAIL reset_misc got=%0h want=0", {full, uf, id_o, lvl_o, ack_id}); end
    endtask

    task automatic test_single();
        irq_valid = 1; irq_id = 5; irq_level = 3;
        tick();
        total++; if (req !== 1'b1 || id_o !== 6'd5 || lvl_o !== 3'd3) begin bad++; $display("[TB] FAIL single_req got=%0d/%0d/%0d want=1/5/3", req, id_o, lvl_o); end
        take = 1;
        tick();
        total++; if (ack !== 1'b1 || ack_id !== 6'd5) begin bad++; $display("[TB] FAIL single_ack got=%0d/%0d want=1/5", ack, ack_id); end
        total++; if (req !== 1'b0) begin bad++; $display("[TB] FAIL single_req_drop got=%0d want=0", req); end
        total++; if (thr !== 3'd3 || depth !== 3'd1) begin bad++; $display("[TB] FAIL single_stack got=%0d/%0d want=3/1", thr, depth); end
        take = 0; irq_valid = 0;
        tick();
        total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL single_ack_pulse got=%0d want=0", ack); end
        tick();
    endtask

    task automatic test_nesting();
        irq_valid = 1; irq_id = 9; irq_level = 5;
        tick();
        total++; if (req !== 1'b1 || id_o !== 6'd9) begin bad++; $display("[TB] FAIL nest_req got=%0d/%0d want=1/9", req, id_o); end
        take = 1;
        tick();
        total++; if (depth !== 3'd2 || thr !== 3'd5 || ack_id !== 6'd9) begin bad++; $display("[TB] FAIL nest_push got=%0d/%0d/%0d want=2/5/9", depth, thr, ack_id); end
        take = 0; irq_valid = 0;
        tick();
        tick();
        irq_valid = 1; irq_id = 2; irq_level = 5;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (req !== 1'b0) begin bad++; $display("[TB] FAIL nest_equal_level cycle=%0d got=%0d want=0", i, req); end
        end
        irq_valid = 0; mret = 1;
        tick();
        mret = 0;
        total++; if (thr !== 3'd3 || depth !== 3'd1) begin bad++; $display("[TB] FAIL nest_pop got=%0d/%0d want=3/1", thr, depth); end
        mret = 1;
        tick();
        mret = 0;
        total++; if (thr !== 3'd0 || depth !== 3'd0) begin bad++; $display("[TB] FAIL nest_empty got=%0d/%0d want=0/0", thr, depth); end
    endtask

    task automatic test_preempt_pend();
        irq_valid = 1; irq_id = 1; irq_level = 2;
        tick();
        total++; if (req !== 1'b1 || id_o !== 6'd1 || lvl_o !== 3'd2) begin bad++; $display("[TB] FAIL pre_cap got=%0d/%0d/%0d want=1/1/2", req, id_o, lvl_o); end
        irq_id = 7; irq_level = 6;
        tick();
        total++; if (req !== 1'b1 || id_o !== 6'd7 || lvl_o !== 3'd6) begin bad++; $display("[TB] FAIL pre_recap got=%0d/%0d/%0d want=1/7/6", req, id_o, lvl_o); end
        irq_level = 3;
        tick();
        total++; if (lvl_o !== 3'd6) begin bad++; $display("[TB] FAIL pre_lower_kept got=%0d want=6", lvl_o); end
        irq_valid = 0;
        tick();
        total++; if (req !== 1'b0) begin bad++; $display("[TB] FAIL pre_withdraw got=%0d want=0", req); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (ack !== 1'b0 || depth !== 3'd0) begin bad++; $display("[TB] FAIL pre_no_ack got=%0d/%0d want=0/0", ack, depth); end
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int l = 1; l <= 4; l++) push_level(6'(20 + l), 3'(l));
        total++; if (full !== 1'b1 || depth !== 3'd4 || thr !== 3'd4) begin bad++; $display("[TB] FAIL full_state got=%0d/%0d/%0d want=1/4/4", full, depth, thr); end
        irq_valid = 1; irq_id = 11; irq_level = 7;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (req !== 1'b0) begin bad++; $display("[TB] FAIL full_no_capture cycle=%0d got=%0d want=0", i, req); end
        end
        mret = 1;
        tick();
        mret = 0;
        total++; if (depth !== 3'd3 || req !== 1'b0 || full !== 1'b0) begin bad++; $display("[TB] FAIL full_free_slot got=%0d/%0d/%0d want=3/0/0", depth, req, full); end
        tick();
        total++; if (req !== 1'b1 || lvl_o !== 3'd7) begin bad++; $display("[TB] FAIL full_capture got=%0d/%0d want=1/7", req, lvl_o); end
        take = 1; mret = 1;
        tick();
        take = 0; mret = 0; irq_valid = 0;
        total++; if (depth !== 3'd3 || thr !== 3'd7 || ack !== 1'b1 || ack_id !== 6'd11) begin bad++; $display("[TB] FAIL full_replace got=%0d/%0d/%0d/%0d want=3/7/1/11", depth, thr, ack, ack_id); end
        tick();
        tick();
    endtask

    task automatic test_underflow_reset();
        apply_reset();
        mret = 1;
        tick();
        mret = 0;
        total++; if (uf !== 1'b1 || depth !== 3'd0 || thr !== 3'd0) begin bad++; $display("[TB] FAIL underflow got=%0d/%0d/%0d want=1/0/0", uf, depth, thr); end
        irq_valid = 1; irq_id = 3; irq_level = 2;
        tick();
        total++; if (req !== 1'b1) begin bad++; $display("[TB] FAIL rst_pend_req got=%0d want=1", req); end
        rst = 1; take = 1;
        tick();
        total++; if ({req, ack, uf, depth, id_o, lvl_o} !== '0) begin bad++; $display("[TB] FAIL rst_mid got=%0h want=0", {req, ack, uf, depth, id_o, lvl_o}); end
        rst = 0; take = 0; irq_valid = 0;
        tick();
        total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_ack got=%0d want=0", ack); end
    endtask

    task automatic test_stats();
        int exp_pre, exp_max;
`ifdef ZEROHETI_NEST_STATS_EN
        exp_pre = 2; exp_max = 3;
`else
        exp_pre = 0; exp_max = 0;
`endif
        apply_reset();
        push_level(6'd30, 3'd1);
        push_level(6'd31, 3'd2);
        push_level(6'd32, 3'd3);
        mret = 1;
        tick();
        tick();
        mret = 0;
        total++; if (depth !== 3'd1) begin bad++; $display("[TB] FAIL stats_depth got=%0d want=1", depth); end
        total++; if (int'(st_pre) != exp_pre) begin bad++; $display("[TB] FAIL stats_preempt got=%0d want=%0d", st_pre, exp_pre); end
        total++; if (int'(st_max) != exp_max) begin bad++; $display("[TB] FAIL stats_maxdep got=%0d want=%0d", st_max, exp_max); end
    endtask

    task automatic test_random();
        int exp_thr, exp_pre, exp_max;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            irq_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) == 0) irq_id = 6'($urandom_range(0, 63));
            irq_level = 3'($urandom_range(0, 7));
            take      = ($urandom_range(0, 2) == 0);
            mret      = ($urandom_range(0, 6) == 0);
            tick();
            exp_thr = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 0;
`ifdef ZEROHETI_NEST_STATS_EN
            exp_pre = m_npre; exp_max = m_maxd;
`else
            exp_pre = 0; exp_max = 0;
`endif
            total++; if (req !== m_pend) begin bad++; $display("[TB] FAIL rnd_req cyc=%0d got=%0d want=%0d", c, req, m_pend); end
            if (m_pend) begin
                total++; if (int'(id_o) != m_pid || int'(lvl_o) != m_plvl) begin bad++; $display("[TB] FAIL rnd_cap cyc=%0d got=%0d/%0d want=%0d/%0d", c, id_o, lvl_o, m_pid, m_plvl); end
            end
            total++; if (ack !== m_ack) begin bad++; $display("[TB] FAIL rnd_ack cyc=%0d got=%0d want=%0d", c, ack, m_ack); end
            if (m_ack) begin
                total++; if (int'(ack_id) != m_ackid) begin bad++; $display("[TB] FAIL rnd_ack_id cyc=%0d got=%0d want=%0d", c, ack_id, m_ackid); end
            end
            total++; if (int'(depth) != m_stk.size() || int'(thr) != exp_thr) begin bad++; $display("[TB] FAIL rnd_stack cyc=%0d got=%0d/%0d want=%0d/%0d", c, depth, thr, m_stk.size(), exp_thr); end
            total++; if (full !== (m_stk.size() == 4) || uf !== m_uf) begin bad++; $display("[TB] FAIL rnd_flags cyc=%0d got=%0d/%0d want=%0d/%0d", c, full, uf, m_stk.size() == 4, m_uf); end
            total++; if (int'(st_pre) != exp_pre || int'(st_max) != exp_max) begin bad++; $display("[TB] FAIL rnd_stats cyc=%0d got=%0d/%0d want=%0d/%0d", c, st_pre, st_max, exp_pre, exp_max); end
        end
        rst = 0; irq_valid = 0; take = 0; mret = 0;
    endtask

    initial begin
        rst = 1; irq_valid = 0; irq_id = 0; irq_level = 0; take = 0; mret = 0;
        m_stk.delete();
        test_reset();
        test_single();
        test_nesting();
        test_preempt_pend();
        test_full();
        test_underflow_reset();
        test_stats();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
